// File: rtl/decode_stage_pkg.sv
// Shared constants for the MIPS decode stage: opcode/funct values, ALU op codes, FSM states.
package decode_stage_pkg;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpSlti  = 6'h0A;
   localparam logic [5:0] OpAndi  = 6'h0C;
   localparam logic [5:0] OpOri   = 6'h0D;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;

   localparam logic [5:0] FnSll = 6'h00;
   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnSlt = 6'h2A;

   typedef enum logic [3:0] {
      AluAdd = 4'd0,
      AluSub = 4'd1,
      AluAnd = 4'd2,
      AluOr  = 4'd3,
      AluSlt = 4'd4,
      AluSll = 4'd5
   } alu_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRead = 2'd1,
      StOut  = 2'd2
   } state_e;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/decode_stage_ctrl.sv
// Combinational instruction decoder: instruction word -> control bits, immediate, destination.
module decode_ctrl
   import decode_stage_pkg::*;
(
   input  logic [31:0] instr_i,
   input  logic [31:2] pc_i,
   output logic [31:0] imm_o,
   output logic [4:0]  dst_o,
   output logic [3:0]  alu_op_o,
   output logic        reg_write_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        branch_o,
   output logic        jump_o,
   output logic        illegal_o
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rt;
   logic [4:0] rd;
   logic [3:0] pc4_hi;
   alu_op_e    alu_op;

   assign opcode = instr_i[31:26];
   assign funct  = instr_i[5:0];
   assign rt     = instr_i[20:16];
   assign rd     = instr_i[15:11];
   // Upper nibble of pc+4: carries into bit 28 only when pc[27:2] is all ones.
   assign pc4_hi = pc_i[31:28] + {3'b000, &pc_i[27:2]};

   always_comb begin
      imm_o       = sext16(instr_i[15:0]);
      dst_o       = 5'd0;
      alu_op      = AluAdd;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      branch_o    = 1'b0;
      jump_o      = 1'b0;
      illegal_o   = 1'b0;
      case (opcode)
         OpRtype: begin
            dst_o = rd;
            case (funct)
               FnAdd:   alu_op = AluAdd;
               FnSub:   alu_op = AluSub;
               FnAnd:   alu_op = AluAnd;
               FnOr:    alu_op = AluOr;
               FnSlt:   alu_op = AluSlt;
               FnSll:   alu_op = AluSll;
               default: begin
                  illegal_o = 1'b1;
                  dst_o     = 5'd0;
               end
            endcase
         end
         OpAddi: dst_o = rt;
         OpAndi: begin
            dst_o  = rt;
            alu_op = AluAnd;
            imm_o  = {16'h0000, instr_i[15:0]};
         end
         OpOri: begin
            dst_o  = rt;
            alu_op = AluOr;
            imm_o  = {16'h0000, instr_i[15:0]};
         end
         OpSlti: begin
            dst_o  = rt;
            alu_op = AluSlt;
         end
         OpLw: begin
            dst_o      = rt;
            mem_read_o = 1'b1;
         end
         OpSw:  mem_write_o = 1'b1;
         OpBeq: begin
            branch_o = 1'b1;
            alu_op   = AluSub;
         end
         OpJ: begin
            jump_o = 1'b1;
            imm_o  = {pc4_hi, instr_i[25:0], 2'b00};
         end
         default: illegal_o = 1'b1;
      endcase
      reg_write_o = (dst_o != 5'd0);
   end

   assign alu_op_o = alu_op;

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: latches one instruction, reads the register file, bypasses writeback,
// and presents a decoded bundle under a valid/ready handshake.
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic        in_ready,
   input  logic        flush,
   output logic [4:0]  rf_read1,
   output logic [4:0]  rf_read2,
   input  logic [31:0] rf_data1,
   input  logic [31:0] rf_data2,
   input  logic        wb_en,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_rs_val,
   output logic [31:0] out_rt_val,
   output logic [31:0] out_imm,
   output logic [4:0]  out_dst,
   output logic [3:0]  out_alu_op,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_branch,
   output logic        out_jump,
   output logic        out_illegal
);

   state_e      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        rs_ovr_en_q, rs_ovr_en_d;
   logic        rt_ovr_en_q, rt_ovr_en_d;
   logic [31:0] rs_ovr_q, rs_ovr_d;
   logic [31:0] rt_ovr_q, rt_ovr_d;

   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        in_xfer;
   logic        out_xfer;

   logic [31:0] dec_imm;
   logic [4:0]  dec_dst;
   logic [3:0]  dec_alu_op;
   logic        dec_reg_write, dec_mem_read, dec_mem_write;
   logic        dec_branch, dec_jump, dec_illegal;

   assign rs       = instr_q[25:21];
   assign rt       = instr_q[20:16];
   assign rf_read1 = rs;
   assign rf_read2 = rt;

   decode_ctrl u_decode_ctrl (
      .instr_i     (instr_q),
      .pc_i        (pc_q[31:2]),
      .imm_o       (dec_imm),
      .dst_o       (dec_dst),
      .alu_op_o    (dec_alu_op),
      .reg_write_o (dec_reg_write),
      .mem_read_o  (dec_mem_read),
      .mem_write_o (dec_mem_write),
      .branch_o    (dec_branch),
      .jump_o      (dec_jump),
      .illegal_o   (dec_illegal)
   );

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         StIdle:  in_ready = 1'b1;
         StOut: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
      // A flushed or reset instruction must never be handed on, and nothing new is taken.
      if (rst || flush) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
      end
      in_xfer  = in_valid && in_ready;
      out_xfer = out_valid && out_ready;
   end

   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      pc_d        = pc_q;
      rs_ovr_en_d = rs_ovr_en_q;
      rt_ovr_en_d = rt_ovr_en_q;
      rs_ovr_d    = rs_ovr_q;
      rt_ovr_d    = rt_ovr_q;

      case (state_q)
         StIdle:  if (in_xfer) state_d = StRead;
         StRead:  state_d = StOut;
         StOut:   if (out_xfer) state_d = in_xfer ? StRead : StIdle;
         default: state_d = StIdle;
      endcase

      if (in_xfer) begin
         instr_d     = in_instr;
         pc_d        = in_pc;
         rs_ovr_en_d = 1'b0;
         rt_ovr_en_d = 1'b0;
         rs_ovr_d    = 32'd0;
         rt_ovr_d    = 32'd0;
      end else if (state_q != StIdle && wb_en && wb_reg != 5'd0) begin
         // Writes landing after the RF address was issued are not seen by rf_data.
         if (wb_reg == rs) begin
            rs_ovr_en_d = 1'b1;
            rs_ovr_d    = wb_data;
         end
         if (wb_reg == rt) begin
            rt_ovr_en_d = 1'b1;
            rt_ovr_d    = wb_data;
         end
      end

      if (flush) state_d = StIdle;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         instr_q     <= 32'd0;
         pc_q        <= 32'd0;
         rs_ovr_en_q <= 1'b0;
         rt_ovr_en_q <= 1'b0;
         rs_ovr_q    <= 32'd0;
         rt_ovr_q    <= 32'd0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         pc_q        <= pc_d;
         rs_ovr_en_q <= rs_ovr_en_d;
         rt_ovr_en_q <= rt_ovr_en_d;
         rs_ovr_q    <= rs_ovr_d;
         rt_ovr_q    <= rt_ovr_d;
      end
   end

   always_comb begin
      out_pc        = 32'd0;
      out_rs_val    = 32'd0;
      out_rt_val    = 32'd0;
      out_imm       = 32'd0;
      out_dst       = 5'd0;
      out_alu_op    = 4'd0;
      out_reg_write = 1'b0;
      out_mem_read  = 1'b0;
      out_mem_write = 1'b0;
      out_branch    = 1'b0;
      out_jump      = 1'b0;
      out_illegal   = 1'b0;
      if (out_valid) begin
         out_pc        = pc_q;
         out_rs_val    = (rs == 5'd0) ? 32'd0 : (rs_ovr_en_q ? rs_ovr_q : rf_data1);
         out_rt_val    = (rt == 5'd0) ? 32'd0 : (rt_ovr_en_q ? rt_ovr_q : rf_data2);
         out_imm       = dec_imm;
         out_dst       = dec_dst;
         out_alu_op    = dec_alu_op;
         out_reg_write = dec_reg_write;
         out_mem_read  = dec_mem_read;
         out_mem_write = dec_mem_write;
         out_branch    = dec_branch;
         out_jump      = dec_jump;
         out_illegal   = dec_illegal;
      end
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  fetch offers an instruction.
REQ-004 in_instr  input  32  MIPS instruction word.
REQ-005 in_pc  input  32  PC of in_instr.
REQ-006 in_ready  output  1  stage accepts in_instr this cycle.
REQ-007 flush  input  1  discard the in-flight instruction (branch/jump redirect).
REQ-008 rf_read1, rf_read2  output  5  register-file read addresses (rs, rt).
REQ-009 rf_data1, rf_data2  input  32  register-file read data, valid one clock after the address.
REQ-010 wb_en, wb_reg[4:0], wb_data[32]  input  writeback port also driving the register file.
REQ-011 out_valid  output  1; out_ready  input  1: downstream handshake.
REQ-012 out_pc[32], out_rs_val[32], out_rt_val[32], out_imm[32], out_dst[5], out_alu_op[4], out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal  outputs: decoded bundle.

Function
REQ-013 FSM states: IDLE, READ, OUT; transfer occurs on in_valid&&in_ready and on out_valid&&out_ready.
REQ-014 IDLE: in_ready=1; on transfer, latch instr/pc and go to READ.
REQ-015 READ: in_ready=0, out_valid=0; rf_read1=instr[25:21], rf_read2=instr[20:16]; next state OUT.
REQ-016 OUT: out_valid=1; rf_read1/2 held; in_ready=out_ready; on out transfer with in transfer go READ (new instr), without go IDLE; else stay OUT with all outputs stable.
REQ-017 Latency: accept edge to out_valid = 2 cycles; max throughput 1 per 2 cycles.
REQ-018 Bypass: during READ or OUT, wb_en && wb_reg!=0 && wb_reg==rs (rt) captures wb_data into an override; out_rs_val (out_rt_val) = override if set, else rf_data; later matching write replaces it; overrides clear on new accept.
REQ-019 Register 0 always reads 0, regardless of rf_data or writeback.
REQ-020 out_dst: rd for R-type, rt for I-type loads/ALU-imm, 0 otherwise; out_reg_write=0 whenever out_dst=0.
REQ-021 Decode: R-type funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x00 sll; opcodes 0x08 addi, 0x0C andi, 0x0D ori, 0x0A slti, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j.
REQ-022 out_imm: sign-extended imm16, except andi/ori zero-extended; j gives {pc+4[31:28], target26, 2'b00}.
REQ-023 lw: mem_read=1, alu_op=ADD; sw: mem_write=1, reg_write=0; beq: branch=1, alu_op=SUB; j: jump=1.
REQ-024 Unknown opcode/funct: out_illegal=1, all write/mem/branch/jump controls 0 (bubble).
REQ-025 flush: synchronous, priority over handshakes; next state IDLE, out_valid=0 next cycle; in_ready=0 while flush=1 (no accept same cycle).

Reset
REQ-026 rst=1: state IDLE, out_valid=0, overrides cleared, all latched/output fields 0, in_ready=1 after the reset cycle.
REQ-027 rst mid-operation discards the in-flight instruction; no output transfer occurs in the reset cycle.

Structure
REQ-028 Shared package holds opcode/funct constants, 4-bit ALU op encodings (ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5) and FSM state encodings.
REQ-029 One sub-module, decode_ctrl: combinational instr -> control/imm/dst/illegal.
REQ-030 Outputs registered or derived only from state and latched fields; no in_instr-to-output combinational path.

Verification
REQ-031 Reset, then addi $8,$0,5 (0x20080005) -> 2 cycles later out_valid=1, out_dst=8, out_imm=5, out_reg_write=1, out_alu_op=ADD.
REQ-032 RF holds $9=7; add $10,$9,$9 with wb_en=1,wb_reg=9,wb_data=0x11 during READ -> out_rs_val=out_rt_val=0x11.
REQ-033 out_ready=0 for 4 cycles in OUT -> all outputs stable, in_ready=0; then out_ready=1, in_valid=1 -> next instr accepted same edge, state READ.
REQ-034 flush=1 in READ -> out_valid stays 0, state IDLE next cycle; flush with in_valid=1 in IDLE -> no accept.
REQ-035 Opcode 0x3F -> out_illegal=1, reg_write/mem_read/mem_write/branch/jump=0; andi imm 0x8000 -> out_imm=0x00008000.
REQ-036 wb_en=1, wb_reg=0, wb_data=0xFFFFFFFF during READ of add $1,$0,$0 -> out_rs_val=out_rt_val=0.
